// File: rtl/sky130_sram_1rw1r_arbiter.sv
// Two-master arbiter and sequencer for the sky130 32x256 1RW1R OpenRAM macro with a fixed 2-cycle read latency.
// Optional feature: define SRAM_ARB_DUAL_RD_EN to dual-issue a contending read onto macro port 1.
module sky130_sram_1rw1r_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rstb,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [NUM_WMASKS-1:0] m0_wmask,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [NUM_WMASKS-1:0] m1_wmask,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,

    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t                  r0;
    req_t                  r1;
    req_t                  win;
    logic                  lose_we;
    logic [ADDR_WIDTH-1:0] lose_addr;
    logic                  both;
    logic                  any_req;
    logic                  dual_ok;
    master_e               prio;
    master_e               win_id;
    master_e               lose_id;

    // Read tag pipeline: stage 1 tracks the issue-register load, stage 2 the macro access cycle.
    logic                  v0_s1;
    logic                  v0_s2;
    master_e               t0_s1;
    master_e               t0_s2;
    logic                  v1_s2;
    master_e               t1_s2;

    assign r0      = {m0_we, m0_wmask, m0_addr, m0_wdata};
    assign r1      = {m1_we, m1_wmask, m1_addr, m1_wdata};
    assign both    = m0_req & m1_req;
    assign any_req = m0_req | m1_req;

    always_comb begin
        win_id = M0;
        if (both) begin
            win_id = prio;
        end else if (m1_req) begin
            win_id = M1;
        end
    end

    assign lose_id   = (win_id == M0) ? M1 : M0;
    assign win       = (win_id == M1) ? r1 : r0;
    assign lose_we   = (win_id == M1) ? m0_we : m1_we;
    assign lose_addr = (win_id == M1) ? m0_addr : m1_addr;

    // NOTE: grants are gated by rstb directly so nothing is accepted while reset is asserted.
    assign m0_gnt = rstb & m0_req & ((win_id == M0) | dual_ok);
    assign m1_gnt = rstb & m1_req & ((win_id == M1) | dual_ok);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prio   <= M0;
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
            v0_s1  <= 1'b0;
            v0_s2  <= 1'b0;
            t0_s1  <= M0;
            t0_s2  <= M0;
        end else begin
            if (both && !dual_ok) begin
                prio <= lose_id;
            end
            if (any_req) begin
                csb0   <= 1'b0;
                web0   <= ~win.we;
                wmask0 <= win.wmask;
                addr0  <= win.addr;
                din0   <= win.wdata;
            end else begin
                csb0   <= 1'b1;
                web0   <= 1'b1;
            end
            v0_s1 <= any_req & ~win.we;
            t0_s1 <= win_id;
            v0_s2 <= v0_s1;
            t0_s2 <= t0_s1;
        end
    end

`ifdef SRAM_ARB_DUAL_RD_EN
    logic    v1_s1;
    master_e t1_s1;

    // The loser may use port 1 only as a read that cannot observe the winner's same-cycle write.
    assign dual_ok = both & ~lose_we & (~win.we | (win.addr != lose_addr));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            csb1  <= 1'b1;
            addr1 <= '0;
            v1_s1 <= 1'b0;
            v1_s2 <= 1'b0;
            t1_s1 <= M0;
            t1_s2 <= M0;
        end else begin
            if (dual_ok) begin
                csb1  <= 1'b0;
                addr1 <= lose_addr;
            end else begin
                csb1  <= 1'b1;
            end
            v1_s1 <= dual_ok;
            t1_s1 <= lose_id;
            v1_s2 <= v1_s1;
            t1_s2 <= t1_s1;
        end
    end
`else
    logic unused_port1;

    assign dual_ok      = 1'b0;
    assign csb1         = 1'b1;
    assign addr1        = '0;
    assign v1_s2        = 1'b0;
    assign t1_s2        = M0;
    assign unused_port1 = ^{dout1, lose_we, lose_addr};
`endif

    logic m0_hit_p0;
    logic m0_hit_p1;
    logic m1_hit_p0;
    logic m1_hit_p1;

    assign m0_hit_p0 = v0_s2 & (t0_s2 == M0);
    assign m0_hit_p1 = v1_s2 & (t1_s2 == M0);
    assign m1_hit_p0 = v0_s2 & (t0_s2 == M1);
    assign m1_hit_p1 = v1_s2 & (t1_s2 == M1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_hit_p0 | m0_hit_p1;
            m1_rvalid <= m1_hit_p0 | m1_hit_p1;
            if (m0_hit_p0) begin
                m0_rdata <= dout0;
            end else if (m0_hit_p1) begin
                m0_rdata <= dout1;
            end
            if (m1_hit_p0) begin
                m1_rdata <= dout0;
            end else if (m1_hit_p1) begin
                m1_rdata <= dout1;
            end
        end
    end

endmodule

// File: tb/tb_sky130_sram_1rw1r_arbiter.sv
// Self-checking bench for sky130_sram_1rw1r_arbiter with a behavioural 1RW1R macro and a read scoreboard.
// Expectations for the contending-read case follow SRAM_ARB_DUAL_RD_EN.
module tb_sky130_sram_1rw1r_arbiter;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic [7:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0;
    logic [31:0] dout0 = '0;
    logic [31:0] dout1 = '0;

    sky130_sram_1rw1r_arbiter dut (
        .clk(clk), .rstb(rstb),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural macro: inputs latched at posedge, write and read performed at the following negedge.
    logic [31:0] mem [256] = '{default: '0};
    logic        s_csb0 = 1'b1, s_web0 = 1'b1, s_csb1 = 1'b1;
    logic [3:0]  s_wmask0 = '0;
    logic [7:0]  s_addr0 = '0, s_addr1 = '0;
    logic [31:0] s_din0 = '0;

    always @(posedge clk) begin
        s_csb0 = csb0; s_web0 = web0; s_wmask0 = wmask0; s_addr0 = addr0; s_din0 = din0;
        s_csb1 = csb1; s_addr1 = addr1;
    end

    always @(negedge clk) begin
        if (!s_csb0 && !s_web0) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wmask0[b]) mem[s_addr0][8*b +: 8] = s_din0[8*b +: 8];
            end
        end
        if (!s_csb0 && s_web0) dout0 = mem[s_addr0];
        if (!s_csb1) dout1 = mem[s_addr1];
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference memory and read scoreboard (expected return cycle and data per master).
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic [31:0] ref_mem [256] = '{default: '0};
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    task automatic book(input bit m, input logic we, input logic [3:0] mask,
                        input logic [7:0] addr, input logic [31:0] data);
        exp_t e;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
            end
        end else begin
            e.cyc  = cyc + 3;
            e.data = ref_mem[addr];
            if (m) q1.push_back(e);
            else   q0.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rstb) begin
            if (m0_rvalid) begin
                if (q0.size() == 0) check("m0_unexpected_rvalid", 1, 0);
                else begin
                    e0 = q0.pop_front();
                    check("m0_rvalid_cycle", cyc, e0.cyc);
                    check("m0_rdata", m0_rdata, e0.data);
                end
            end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
                check("m0_missing_rvalid", cyc, q0[0].cyc + 1000);
                void'(q0.pop_front());
            end
            if (m1_rvalid) begin
                if (q1.size() == 0) check("m1_unexpected_rvalid", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    check("m1_rvalid_cycle", cyc, e1.cyc);
                    check("m1_rdata", m1_rdata, e1.data);
                end
            end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
                check("m1_missing_rvalid", cyc, q1[0].cyc + 1000);
                void'(q1.pop_front());
            end
        end
    end

    task automatic set_m0(input logic req, input logic we, input logic [3:0] mask,
                          input logic [7:0] addr, input logic [31:0] data);
        m0_req = req; m0_we = we; m0_wmask = mask; m0_addr = addr; m0_wdata = data;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [3:0] mask,
                          input logic [7:0] addr, input logic [31:0] data);
        m1_req = req; m1_we = we; m1_wmask = mask; m1_addr = addr; m1_wdata = data;
    endtask

    // Called after the inputs were driven at a negedge: checks grants, books accepted ops, waits for the posedge.
    task automatic accept(input string name, input logic eg0, input logic eg1);
        #1;
        check({name, ".m0_gnt"}, m0_gnt, eg0);
        check({name, ".m1_gnt"}, m1_gnt, eg1);
        if (m0_req && m0_gnt) book(1'b0, m0_we, m0_wmask, m0_addr, m0_wdata);
        if (m1_req && m1_gnt) book(1'b1, m1_we, m1_wmask, m1_addr, m1_wdata);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".csb0"}, csb0, 1'b1);
        check({name, ".csb1"}, csb1, 1'b1);
        check({name, ".web0"}, web0, 1'b1);
        check({name, ".wmask0"}, wmask0, 4'h0);
        check({name, ".addr0"}, addr0, 8'h00);
        check({name, ".addr1"}, addr1, 8'h00);
        check({name, ".din0"}, din0, 32'h0);
        check({name, ".m0_rvalid"}, m0_rvalid, 1'b0);
        check({name, ".m1_rvalid"}, m1_rvalid, 1'b0);
        check({name, ".m0_rdata"}, m0_rdata, 32'h0);
        check({name, ".m1_rdata"}, m1_rdata, 32'h0);
        check({name, ".m0_gnt"}, m0_gnt, 1'b0);
        check({name, ".m1_gnt"}, m1_gnt, 1'b0);
    endtask

    initial begin
        // Reset: requests held high must not be granted.
        m0_req = 1'b1;
        m1_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        rstb = 1'b1;
        @(posedge clk);

        // Round-robin: both write continuously, grants alternate starting with m0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i % 2 == 0) set_m0(1'b1, 1'b1, 4'hF, 8'h50, 32'h5000_0000 + i);
            set_m1(1'b1, 1'b1, 4'hF, 8'h60, (i % 2 == 1) ? 32'h6000_0000 + i : m1_wdata);
            if (i == 0) set_m1(1'b1, 1'b1, 4'hF, 8'h60, 32'h6000_0001);
            accept($sformatf("rr%0d", i), (i % 2 == 0), (i % 2 == 1));
        end

        // Single write then read.
        @(negedge clk);
        set_m1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        set_m0(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        accept("wr10", 1'b1, 1'b0);
        @(negedge clk);
        set_m0(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        accept("rd10", 1'b1, 1'b0);
        idle(4);
        check("rd10.value", m0_rdata, 32'hDEADBEEF);

        // Byte mask, then an all-zero mask that must leave the word unchanged.
        @(negedge clk);
        set_m0(1'b1, 1'b1, 4'hF, 8'h20, 32'h11223344);
        accept("wr20", 1'b1, 1'b0);
        @(negedge clk);
        set_m0(1'b1, 1'b1, 4'b0101, 8'h20, 32'hAABBCCDD);
        accept("wr20_mask", 1'b1, 1'b0);
        @(negedge clk);
        set_m0(1'b1, 1'b1, 4'b0000, 8'h20, 32'hFFFFFFFF);
        accept("wr20_nomask", 1'b1, 1'b0);
        @(negedge clk);
        set_m0(1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
        accept("rd20", 1'b1, 1'b0);
        @(negedge clk);
        set_m0(1'b1, 1'b0, 4'h0, 8'h60, 32'h0);
        accept("rd60", 1'b1, 1'b0);
        idle(4);
        check("rd60.value", m0_rdata, 32'h6000_0005);

        // Same-address hazard with prio on m0: m1's read waits one cycle and sees the new data.
        @(negedge clk);
        set_m0(1'b1, 1'b1, 4'hF, 8'h40, 32'h12345678);
        set_m1(1'b1, 1'b0, 4'h0, 8'h40, 32'h0);
        accept("hazard", 1'b1, 1'b0);
        @(negedge clk);
        set_m0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        accept("hazard_rd", 1'b0, 1'b1);
        idle(4);
        check("hazard.value", m1_rdata, 32'h12345678);

        // Contending reads of different addresses (prio now favours m1).
        @(negedge clk);
        set_m1(1'b1, 1'b1, 4'hF, 8'h30, 32'hCAFEF00D);
        accept("wr30", 1'b0, 1'b1);
        @(negedge clk);
        set_m0(1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
        set_m1(1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
`ifdef SRAM_ARB_DUAL_RD_EN
        accept("dual", 1'b1, 1'b1);
`else
        accept("dual", 1'b0, 1'b1);
        @(negedge clk);
        m1_req = 1'b0;
        accept("dual_2nd", 1'b1, 1'b0);
`endif
        idle(4);
        check("dual.m0_value", m0_rdata, 32'h11BB33DD);
        check("dual.m1_value", m1_rdata, 32'hCAFEF00D);

        // Reset one cycle after a read grant: the read is dropped.
        @(negedge clk);
        set_m0(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        accept("rd_rst", 1'b1, 1'b0);
        @(negedge clk);
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        rstb = 1'b0;
        q0.delete();
        q1.delete();
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst.m0_rvalid_after", m0_rvalid, 1'b0);

        check("end.q0_pending", q0.size(), 0);
        check("end.q1_pending", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sky130_sram_1rw1r_arbiter.md
# sky130_sram_1rw1r_arbiter

Two-master arbiter and sequencer for the 32x256 1RW1R OpenRAM macro (port 0 read/write, port 1 read-only, byte write mask of 4). It shares the macro between two requesters with a fixed 2-cycle read latency. When the macro's port 1 is enabled, it dual-issues a contending read onto port 1. All macro-side pins are driven from registers so the macro's posedge input sampling always sees stable values.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must match the macro.
- ADDR_WIDTH, 8, word address width.
- NUM_WMASKS, 4, byte-lane write-mask width (DATA_WIDTH/8).

Ports:
- clk  in  1  single clock; the macro's clk0 and clk1 are tied to it at the top level.
- rstb  in  1  asynchronous active-low reset.
- m0_req / m1_req  in  1  request; must be held with its fields stable until granted.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_wmask / m1_wmask  in  NUM_WMASKS  byte enables for a write.
- m0_addr / m1_addr  in  ADDR_WIDTH  word address.
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
- m0_gnt / m1_gnt  out  1  combinational grant; req&gnt at a posedge = accepted.
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data strobe.
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid when rvalid.
- csb0, web0  out  1  macro port 0 chip select / write enable (active low).
- wmask0  out  NUM_WMASKS  macro port 0 write mask.
- addr0  out  ADDR_WIDTH  macro port 0 address.
- din0  out  DATA_WIDTH  macro port 0 write data.
- dout0  in  DATA_WIDTH  macro port 0 read data.
- csb1  out  1  macro port 1 chip select.
- addr1  out  ADDR_WIDTH  macro port 1 address.
- dout1  in  DATA_WIDTH  macro port 1 read data.

## Operation
- Priority register prio (0 = m0 preferred). Reset value 0.
- Exactly one requester: it is granted on port 0 (read or write).
- Both requesting: the prio winner is granted on port 0. The loser is also granted on port 1 only if all of the following hold:
  - the loser is a read;
  - SRAM_ARB_DUAL_RD_EN is defined;
  - the winner is a read, or the winner is a write whose address differs from the loser's.
  - Otherwise the loser waits.
- prio update: flips to the loser only when both requested and only one was granted; otherwise unchanged.
- Writes are only ever issued on port 0. A write is complete at grant and returns no response. wmask 0000 is legal: it is granted and no bytes change.
- Issue registers, loaded at the accepting posedge:
  - port 0: csb0=0, web0=~we, wmask0, addr0, din0;
  - port 1: csb1=0, addr1.
  - A slot with no grant loads csb=1 and holds addr/din/wmask, with web0=1.
- Tag pipeline: a destination-master tag plus a valid bit per port track each read to its return cycle. Reads on both ports in one cycle go to different masters, so each master receives at most one rvalid per cycle.
- Read return: on the posedge after the issue-register load, dout0/dout1 are captured into the tagged master's rdata, and that master's rvalid is set for one cycle.
- rdata holds its last value when rvalid=0.

## Timing
- Cycle N: req&gnt sampled at posedge N.
- Posedge N+1: the macro samples the issue registers.
- After negedge N+1: macro dout is valid.
- Posedge N+2: rdata is captured and rvalid=1 during cycle N+2.
- Read latency is fixed at 2 cycles. Throughput is 1 op/cycle per port, fully pipelined, with no bubbles between back-to-back grants.
- Reset values: csb0=1, csb1=1, web0=1, wmask0=0, addr0=0, addr1=0, din0=0, m0/m1_rvalid=0, m0/m1_rdata=0, prio=0.
- gnt=0 while rstb=0.
- Reset asserted mid-operation: in-flight reads are dropped (tag valids cleared) and no rvalid is produced for them. Ops accepted before reset may or may not have reached the array.

## Configuration
- SRAM_ARB_DUAL_RD_EN defined: port 1 is used for the contending read as described in Operation.
- SRAM_ARB_DUAL_RD_EN undefined:
  - csb1 is tied to 1 and addr1 to 0;
  - the port-1 tag pipeline is removed;
  - at most one grant per cycle, so contention always stalls the loser.

## Test plan
- Single write then read: m0 writes addr 0x10, data 0xDEADBEEF, wmask 1111, then reads 0x10 → m0_rvalid exactly 2 cycles after the read grant, m0_rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 to 0x20, then 0xAABBCCDD with wmask 0101, then read → 0x11BB33DD.
- Dual read (macro defined): both masters read 0x20 / 0x30 in the same cycle → both granted; both rvalids are in the same cycle, each carrying its own address's data.
- Write/read same-address hazard: prio=m0, m0 writes 0x40, m1 reads 0x40 → only m0 is granted. m1 is granted the next cycle and returns the new data.
- Round-robin fairness: both masters issue continuous writes for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1.
- Reset mid-read: assert rstb low at cycle N+1 after a read grant → no rvalid; all outputs are at their reset values immediately.
